// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan controller.
// Segment positions, hex glyph table and idle output codes.
package seg7_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam int BLANK_BIT = 5;
  localparam int DP_BIT    = 4;

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [3:0] DIG_OFF = 4'b1111;

  localparam logic [5:0] ENTRY_BLANK = 6'b100000;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2,
    8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E,
    8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Display entry to segment pattern.
// Blank entries force all segments off; dp lands in bit 0.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [5:0] entry,
  output logic [7:0] seg
);

  // glyph lookup, then decimal point, unless blanked
  always_comb begin
    seg = SEG_OFF;
    if (!entry[BLANK_BIT]) begin
      seg[SEG_A:SEG_G] = HEX_SEG[entry[3:0]][SEG_A:SEG_G];
      seg[SEG_DP]      = entry[DP_BIT];
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan of four common-anode digits with blanking gaps.
// Host fills shadow entries; commit copies them on a frame boundary.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 27_000,
  parameter int BLANK_CYCLES = 270,
  parameter int NUM_DIGITS   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [1:0] i_wr_addr,
  input  logic [5:0] i_wr_data,
  input  logic       i_commit,
  input  logic [3:0] i_en_mask,
  output logic [7:0] o_seg,
  output logic [3:0] o_dig,
  output logic       o_frame
);

  localparam int CW =
    (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT =
    CW'(DIGIT_CYCLES - 1);
  localparam logic [CW:0] BLANK_END =
    (CW+1)'(BLANK_CYCLES);
  localparam logic [1:0] LAST_DIG =
    2'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          pending;
  logic [5:0]    shadow [4];
  logic [5:0]    active [4];

  logic          frame_end;
  logic          in_blank;
  logic [7:0]    cur_seg;
  logic [7:0]    seg_nxt;
  logic [3:0]    dig_nxt;

  assign frame_end  = (cnt == LAST_CNT) && (idx == LAST_DIG);
  assign in_blank   = ({1'b0, cnt} < BLANK_END);
  assign o_wr_ready = ~pending;

  seg7_hex_decode u_dec (
    .entry (active[idx]),
    .seg   (cur_seg)
  );

  // slot counter and digit index
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == LAST_CNT) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // host writes land in shadow while not waiting on a commit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) shadow[i] <= ENTRY_BLANK;
    end else if (i_wr_valid && o_wr_ready) begin
      shadow[i_wr_addr] <= i_wr_data;
    end
  end

  // commit waits for frame end so a frame never mixes old and new
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending <= 1'b0;
      for (int i = 0; i < 4; i++) active[i] <= ENTRY_BLANK;
    end else if (frame_end && pending) begin
      pending <= 1'b0;
      for (int i = 0; i < 4; i++) active[i] <= shadow[i];
    end else if (i_commit && !pending) begin
      pending <= 1'b1;
    end
  end

  // next segment/select values for the current slot phase
  always_comb begin
    seg_nxt = SEG_OFF;
    dig_nxt = DIG_OFF;
    if (!in_blank && i_en_mask[idx]) begin
      seg_nxt = cur_seg;
      dig_nxt = DIG_OFF & ~(4'b0001 << idx);
    end
  end

  // registered pad drivers and frame strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_seg   <= SEG_OFF;
      o_dig   <= DIG_OFF;
      o_frame <= 1'b0;
    end else begin
      o_seg   <= seg_nxt;
      o_dig   <= dig_nxt;
      o_frame <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 8-cycle slots, 2 blank.
// Frames are 32 cycles; outputs are sampled on the falling edge.
module tb_seg7_scan_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_wr_valid = 1'b0;
  logic       o_wr_ready;
  logic [1:0] i_wr_addr = 2'd0;
  logic [5:0] i_wr_data = 6'd0;
  logic       i_commit = 1'b0;
  logic [3:0] i_en_mask = 4'b1111;
  logic [7:0] o_seg;
  logic [3:0] o_dig;
  logic       o_frame;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  seg7_scan_ctrl #(
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2),
    .NUM_DIGITS   (4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_valid (i_wr_valid),
    .o_wr_ready (o_wr_ready),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_commit   (i_commit),
    .i_en_mask  (i_en_mask),
    .o_seg      (o_seg),
    .o_dig      (o_dig),
    .o_frame    (o_frame)
  );

  // expected {dig, seg} at frame position j (1..32)
  function automatic logic [11:0] exp_out(
    input int j,
    input logic [3:0] m,
    input logic [3:0][7:0] s
  );
    int d;
    int c;
    d = (j - 1) / 8;
    c = (j - 1) % 8;
    if (c < 2 || !m[d]) return {4'b1111, 8'h00};
    return {~(4'b0001 << d), s[d]};
  endfunction

  // drive one host transaction, hold until accepted
  task automatic host_op(
    input logic [1:0] a,
    input logic [5:0] d,
    input logic wr,
    input logic cm,
    output bit ok
  );
    int n;
    n = 0;
    i_wr_addr  = a;
    i_wr_data  = d;
    i_wr_valid = wr;
    i_commit   = cm;
    while (!o_wr_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    ok = o_wr_ready;
    @(negedge i_clk);
    i_wr_valid = 1'b0;
    i_commit   = 1'b0;
  endtask

  // block until the next o_frame pulse, bounded
  task automatic wait_frame(output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_frame && n < 100);
    ok = o_frame;
  endtask

  task automatic test_reset;
    logic [11:0] e;
    logic [3:0][7:0] s;
    s = '0;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    checks += 4;
    if (o_seg !== 8'h00) begin
      errors++;
      $display("FAIL rst_seg: got %h want 00", o_seg);
    end
    if (o_dig !== 4'b1111) begin
      errors++;
      $display("FAIL rst_dig: got %b want 1111", o_dig);
    end
    if (o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b want 1", o_wr_ready);
    end
    if (o_frame !== 1'b0) begin
      errors++;
      $display("FAIL rst_frame: got %b want 0", o_frame);
    end
    i_rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge i_clk);
      e = exp_out(((k - 1) % 32) + 1, 4'b1111, s);
      checks += 2;
      if ({o_dig, o_seg} !== e) begin
        errors++;
        $display("FAIL rst_scan k=%0d: got %h want %h",
                 k, {o_dig, o_seg}, e);
      end
      if (o_frame !== (k % 32 == 0)) begin
        errors++;
        $display("FAIL rst_frame_pulse k=%0d: got %b", k, o_frame);
      end
    end
  endtask

  task automatic test_write_commit;
    logic [11:0] e;
    logic [3:0][7:0] s;
    bit ok;
    int n;
    s = {8'hFF, 8'h00, 8'h00, 8'hF2};
    host_op(2'd0, 6'h03, 1'b1, 1'b0, ok);
    host_op(2'd3, 6'h18, 1'b1, 1'b0, ok);
    host_op(2'd0, 6'h00, 1'b0, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wc_accept: commit not accepted");
    end
    n = 0;
    do begin
      checks += 2;
      if (o_seg !== 8'h00) begin
        errors++;
        $display("FAIL wc_early_seg: got %h want 00", o_seg);
      end
      if (o_wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL wc_pend_ready: got %b want 0", o_wr_ready);
      end
      @(negedge i_clk);
      n++;
    end while (!o_frame && n < 100);
    checks += 2;
    if (o_frame !== 1'b1) begin
      errors++;
      $display("FAIL wc_frame_timeout: got %b want 1", o_frame);
    end
    if (o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wc_ready_back: got %b want 1", o_wr_ready);
    end
    for (int j = 1; j <= 32; j++) begin
      @(negedge i_clk);
      e = exp_out(j, 4'b1111, s);
      checks++;
      if ({o_dig, o_seg} !== e) begin
        errors++;
        $display("FAIL wc_scan j=%0d: got %h want %h",
                 j, {o_dig, o_seg}, e);
      end
    end
  endtask

  task automatic test_commit_then_write;
    logic [11:0] e;
    logic [3:0][7:0] s;
    bit ok;
    int n;
    s = {8'hFF, 8'h00, 8'h60, 8'hF2};
    i_commit = 1'b1;
    @(negedge i_clk);
    i_commit   = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_addr  = 2'd1;
    i_wr_data  = 6'h01;
    n = 0;
    do begin
      checks++;
      if (o_wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL cw_ready_low n=%0d: got %b want 0",
                 n, o_wr_ready);
      end
      @(negedge i_clk);
      n++;
    end while (!o_frame && n < 100);
    checks += 2;
    if (o_frame !== 1'b1) begin
      errors++;
      $display("FAIL cw_frame_timeout: got %b want 1", o_frame);
    end
    if (o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL cw_ready_back: got %b want 1", o_wr_ready);
    end
    @(negedge i_clk);
    i_wr_valid = 1'b0;
    host_op(2'd0, 6'h00, 1'b0, 1'b1, ok);
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cw_frame2_timeout: got 0 want 1");
    end
    for (int j = 1; j <= 32; j++) begin
      @(negedge i_clk);
      e = exp_out(j, 4'b1111, s);
      checks++;
      if ({o_dig, o_seg} !== e) begin
        errors++;
        $display("FAIL cw_scan j=%0d: got %h want %h",
                 j, {o_dig, o_seg}, e);
      end
    end
  endtask

  task automatic test_same_cycle;
    logic [11:0] e;
    logic [3:0][7:0] s;
    bit ok;
    s = {8'hFF, 8'h9E, 8'h60, 8'hF2};
    host_op(2'd2, 6'h0E, 1'b1, 1'b1, ok);
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sc_frame_timeout: got 0 want 1");
    end
    for (int j = 1; j <= 32; j++) begin
      @(negedge i_clk);
      e = exp_out(j, 4'b1111, s);
      checks++;
      if ({o_dig, o_seg} !== e) begin
        errors++;
        $display("FAIL sc_scan j=%0d: got %h want %h",
                 j, {o_dig, o_seg}, e);
      end
    end
  endtask

  task automatic test_mask;
    logic [11:0] e;
    logic [3:0][7:0] s;
    bit ok;
    s = {8'hFF, 8'h9E, 8'h60, 8'hF2};
    i_en_mask = 4'b1011;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mk_frame_timeout: got 0 want 1");
    end
    for (int j = 1; j <= 32; j++) begin
      @(negedge i_clk);
      e = exp_out(j, 4'b1011, s);
      checks++;
      if ({o_dig, o_seg} !== e) begin
        errors++;
        $display("FAIL mk_scan j=%0d: got %h want %h",
                 j, {o_dig, o_seg}, e);
      end
    end
    i_en_mask = 4'b1111;
  endtask

  task automatic test_reset_mid;
    logic [11:0] e;
    logic [3:0][7:0] s;
    bit ok;
    int n;
    s = '0;
    host_op(2'd0, 6'h05, 1'b1, 1'b0, ok);
    host_op(2'd0, 6'h00, 1'b0, 1'b1, ok);
    n = 0;
    while (o_dig === 4'b1111 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    checks += 2;
    if (o_dig === 4'b1111) begin
      errors++;
      $display("FAIL rm_show_timeout: got %b", o_dig);
    end
    if (o_wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rm_pending: got %b want 0", o_wr_ready);
    end
    i_rst = 1'b1;
    #1;
    checks += 4;
    if (o_seg !== 8'h00) begin
      errors++;
      $display("FAIL rm_seg: got %h want 00", o_seg);
    end
    if (o_dig !== 4'b1111) begin
      errors++;
      $display("FAIL rm_dig: got %b want 1111", o_dig);
    end
    if (o_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_ready: got %b want 1", o_wr_ready);
    end
    if (o_frame !== 1'b0) begin
      errors++;
      $display("FAIL rm_frame: got %b want 0", o_frame);
    end
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge i_clk);
      e = exp_out(((k - 1) % 32) + 1, 4'b1111, s);
      checks += 2;
      if ({o_dig, o_seg} !== e) begin
        errors++;
        $display("FAIL rm_scan k=%0d: got %h want %h",
                 k, {o_dig, o_seg}, e);
      end
      if (o_wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL rm_ready_after k=%0d: got %b", k, o_wr_ready);
      end
    end
    host_op(2'd0, 6'h00, 1'b0, 1'b1, ok);
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rm_frame_timeout: got 0 want 1");
    end
    for (int j = 1; j <= 32; j++) begin
      @(negedge i_clk);
      e = exp_out(j, 4'b1111, s);
      checks++;
      if ({o_dig, o_seg} !== e) begin
        errors++;
        $display("FAIL rm_shadow_scan j=%0d: got %h want %h",
                 j, {o_dig, o_seg}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_commit_then_write();
    test_same_cycle();
    test_mask();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
